// File: rtl/window_filter_pipe.sv
// window_filter_pipe: two-stage 3x3 window filter (mean, Gaussian, centre, minimum) with valid/ready flow control
module window_filter_pipe #(
    parameter int DW = 8,
    parameter int CH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [9*CH*DW-1:0]   in_win,
    input  logic [1:0]           in_mode,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CH*DW-1:0]     out_pix,
    output logic                 out_last
);
    localparam int SW = DW + 3;
    localparam int TW = DW + 4;
    logic       s1_valid;
    logic [1:0] s1_mode;
    logic       s1_last;
    logic       s2_adv;
    logic       s1_adv;
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;
    // Valid bits and sideband (mode, last) advance with their beat through both stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= 2'd0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (in_valid && s1_adv) begin
                s1_mode <= in_mode;
                s1_last <= in_last;
            end
            if (s2_adv) out_valid <= s1_valid;
            if (s1_valid && s2_adv) out_last <= s1_last;
        end
    end
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [DW-1:0] p [9];
        logic [SW-1:0] row_nx [3];
        logic [SW-1:0] row [3];
        logic [DW-1:0] ctr;
        logic [TW-1:0] s;
        logic [TW-1:0] m;
        logic [DW-1:0] avg, gau, q0, q1, q2, mn01, mn, res, o;
        for (genvar k = 0; k < 9; k++) begin : g_px
            assign p[k] = in_win[(k*CH+c)*DW +: DW];
        end
        for (genvar r = 0; r < 3; r++) begin : g_row
            logic [SW-1:0] box, wsum;
            logic [DW-1:0] lo;
            assign box       = SW'(p[3*r]) + SW'(p[3*r+1]) + SW'(p[3*r+2]);
            assign wsum      = SW'(p[3*r]) + (SW'(p[3*r+1]) << 1) + SW'(p[3*r+2]);
            assign lo        = (p[3*r] < p[3*r+1]) ? p[3*r] : p[3*r+1];
            assign row_nx[r] = (in_mode == 2'd3) ? SW'((lo < p[3*r+2]) ? lo : p[3*r+2]) :
                               (in_mode == 2'd1) ? ((r == 1) ? (wsum << 1) : wsum) : box;
        end
        // Stage 1 holds the three row partials and the centre pixel of this channel
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                row <= '{default: '0};
                ctr <= '0;
            end else if (in_valid && s1_adv) begin
                row <= row_nx;
                ctr <= p[4];
            end
        end
        assign s    = TW'(row[0]) + TW'(row[1]) + TW'(row[2]);
        assign m    = s >> 3;
        assign avg  = DW'(m - (m >> 3));
        assign gau  = DW'(s >> 4);
        assign q0   = DW'(row[0]);
        assign q1   = DW'(row[1]);
        assign q2   = DW'(row[2]);
        assign mn01 = (q0 < q1) ? q0 : q1;
        assign mn   = (mn01 < q2) ? mn01 : q2;
        assign res  = (s1_mode == 2'd0) ? avg :
                      (s1_mode == 2'd1) ? gau :
                      (s1_mode == 2'd2) ? ctr : mn;
        // Stage 2 result register drives this channel's slice of out_pix
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) o <= '0;
            else if (s1_valid && s2_adv) o <= res;
        end
        assign out_pix[c*DW +: DW] = o;
    end
endmodule

// File: doc/window_filter_pipe.md
# window_filter_pipe

Parametrised, pipelined successor to the combinational 3x3 window filter in the transmission-estimation path. It accepts one fully-formed 3x3 window per beat for CH colour channels of DW bits, applies a per-beat selectable kernel (box mean, 1-2-4 Gaussian, centre bypass, or window minimum for dark-channel erosion), and returns one filtered pixel per channel. It sits between the line-buffer/window generator and the transmission/atmospheric-light stages, with valid/ready handshakes on both sides and full-throughput backpressure support.

## Interface
- DW, 8, bits per channel sample
- CH, 3, channels processed in parallel with identical kernels
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  window beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_win  input  9*CH*DW  window; pixel k (0..8 raster order, 0 = top-left, 4 = centre), channel c at bits [(k*CH+c)*DW +: DW]
- in_mode  input  2  kernel: 0 mean, 1 Gaussian, 2 centre bypass, 3 minimum
- in_last  input  1  sideband tag (end-of-line/frame), carried unchanged with the beat
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_pix  output  CH*DW  result; channel c at bits [c*DW +: DW]
- out_last  output  1  in_last of the beat that produced out_pix

## Operation
- Beat accepted when in_valid && in_ready; in_mode and in_last are captured with the data and travel down the pipe, so a mode change affects only beats accepted afterwards.
- Two register stages, S1 and S2; S2 registers drive out_valid/out_pix/out_last directly.
- S1 per channel: the three row partials (weighted sums for modes 0/1, row minima for mode 3) and the centre pixel, each sum DW+3 bits wide.
- S2 per channel, sum width DW+4, truncating shifts only:
  - mode 0: s = sum of all 9; m = s>>3; out = m - (m>>3) (≈ s/9.14)
  - mode 1: weights corners 1, edges 2, centre 4; out = s>>4
  - mode 2: out = pixel 4
  - mode 3: out = min of the 9 pixels
- Results always fit in DW bits (mode 0 maximum is 63/64 of full scale); no saturation logic. The bench asserts that the upper bits are zero before truncation.
- Channels are fully independent; no cross-channel arithmetic.
- Pipeline control:
  - s2_adv = !out_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv (combinational from out_ready; no storage beyond S1/S2)
  - S1 loads when in_valid && s1_adv. S2 loads S1 contents when s1_valid && s2_adv.
  - out_valid clears when out_ready is high and S2 is not reloaded.
- While stalled (out_valid && !out_ready), out_pix/out_last are held stable and the beat in S1 is held.
- Reset (asynchronous assert, synchronous deassert handled externally): s1_valid = 0, out_valid = 0, out_pix = 0, out_last = 0, all datapath registers = 0. in_ready reads 1 during and after reset. Reset mid-stream discards both in-flight beats; no partial output follows.

## Timing
- Latency: a beat accepted at edge N appears on out_valid/out_pix after edge N+2 when unstalled.
- Throughput: 1 beat/cycle sustained with out_ready held high.
- in_ready falls in the same cycle that both stages are full and out_ready is low; it rises combinationally when out_ready rises.
- Simultaneous S2 drain and S1 refill in one cycle is lossless. Order is strictly preserved.
- out_last is aligned with its own beat's out_pix in every cycle.

## Test plan
- Mode 0, all samples 255, CH=3 -> every channel 251 at cycle N+2 (s=2295, m=286, 286-35).
- Mode 1, pixels k=0..8 = 10,20,...,90 on all channels -> 50 on each channel (800>>4). Mode 2 on the same window -> 50. Mode 3 on the same window -> 10.
- 16 back-to-back beats, alternating in_mode 0/3, out_ready=1 -> 16 results in order, one per cycle, each result matching its own mode; in_ready stays 1.
- Same stream with out_ready low for cycles 4-6 -> in_ready low while both stages are full, out_pix stable during the stall, no loss or duplication, out_last set only on beat 15.
- rst_n pulsed low while two beats are in flight -> out_valid=0 and out_pix=0 immediately. After release, the next accepted beat emerges at +2 cycles with no stale output beforehand.
- Per-channel independence: channel 0 all 0, channel 1 all 255, channel 2 centre 200 with the rest 0, mode 1 -> out_pix = {50, 255, 0}, with channel 2 at [2*DW +: DW] and channel 0 at [0 +: DW].
